// File: rtl/timing_attack_pkg.sv
//------------------------------------------------------------------------------
// Module   : timing_attack_pkg
// Brief    : Shared protocol bytes, guess range, delay width and scan FSM
//            state encoding for the timing-attack guessing controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package timing_attack_pkg;

    // Serial protocol bytes exchanged with the target
    localparam logic [7:0] START_BYTE        = 8'h01;
    localparam logic [7:0] BEGIN_GUESSING    = 8'h02;
    localparam logic [7:0] YES               = 8'h03;
    localparam logic [7:0] NO                = 8'h04;
    localparam logic [7:0] END_BYTE          = 8'h05;

    // First byte value that is a real guess (lower values are protocol bytes)
    localparam logic [7:0] START_GUESS_RANGE = 8'h06;

    // Width of a measured reply-delay count
    localparam int         DELAY_W           = 32;

    // Peak-finder scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_LAST   = 3'd3,
        ST_REPORT = 3'd4
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/delay_ram.sv
//------------------------------------------------------------------------------
// Module   : delay_ram
// Brief    : 256 x DELAY_W simple dual-port RAM, one write port and one
//            synchronous read port (1-cycle latency). No reset so it maps
//            onto block RAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module delay_ram #(
    parameter int DELAY_W = 32
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [7:0]         wr_addr,
    input  logic [DELAY_W-1:0] wr_data,
    input  logic [7:0]         rd_addr,
    output logic [DELAY_W-1:0] rd_data
);

    logic [DELAY_W-1:0] r_mem [256];

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/delay_peak_finder.sv
//------------------------------------------------------------------------------
// Module   : delay_peak_finder
// Brief    : Stores one reply delay per guess byte and sequentially scans
//            SCAN_FIRST..SCAN_LAST to report the longest delay, its byte,
//            the runner-up delay and the margin between them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module delay_peak_finder #(
    parameter int         DELAY_W    = 32,
    parameter logic [7:0] SCAN_FIRST = 8'h06,
    parameter logic [7:0] SCAN_LAST  = 8'hFF
) (
    input  logic               CLK_50,
    input  logic               SW,
    input  logic               wr_en,
    input  logic [7:0]         wr_addr,
    input  logic [DELAY_W-1:0] wr_data,
    input  logic               clear,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [7:0]         max_byte,
    output logic [DELAY_W-1:0] max_delay,
    output logic [DELAY_W-1:0] runner_delay,
    output logic [DELAY_W-1:0] margin,
    output logic               found,
    output logic               wr_collision
);

    import timing_attack_pkg::*;

    // A one-entry range skips the SCAN state entirely
    localparam bit c_SINGLE = (SCAN_FIRST == SCAN_LAST);

    scan_state_t        r_state;
    logic [7:0]         r_addr;      // address presented to the RAM read port
    logic [7:0]         r_rd_addr;   // address of the word now on w_rd_data
    logic               r_rd_valid;  // valid tag of the word now on w_rd_data
    logic [255:0]       r_valid;
    logic [DELAY_W-1:0] w_rd_data;
    logic [DELAY_W-1:0] w_entry;
    logic [DELAY_W-1:0] r_best;
    logic [DELAY_W-1:0] r_runner;
    logic [7:0]         r_idx;
    logic [DELAY_W-1:0] w_best_n;
    logic [DELAY_W-1:0] w_runner_n;
    logic [7:0]         w_idx_n;
    logic               w_busy;
    logic               w_start_ok;
    logic               w_wr_ok;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_start_ok = start & ~clear & ~w_busy;
    assign w_wr_ok    = wr_en & ~clear & ~w_busy;
    assign busy       = w_busy;

    // Entries never written since the last clear/reset read as zero
    assign w_entry    = r_rd_valid ? w_rd_data : '0;

    delay_ram #(
        .DELAY_W (DELAY_W)
    ) u_delay_ram (
        .clk     (CLK_50),
        .wr_en   (w_wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (r_addr),
        .rd_data (w_rd_data)
    );

    // Strict-greater compare: ties keep the earlier (lower) index
    always_comb begin
        w_best_n   = r_best;
        w_runner_n = r_runner;
        w_idx_n    = r_idx;
        if (w_entry > r_best) begin
            w_runner_n = r_best;
            w_best_n   = w_entry;
            w_idx_n    = r_rd_addr;
        end else if (w_entry > r_runner) begin
            w_runner_n = w_entry;
        end
    end

    // Valid bitmap: set on accepted write, wiped by clear or reset
    always_ff @(posedge CLK_50 or posedge SW) begin
        if (SW) begin
            r_valid <= '0;
        end else if (clear) begin
            r_valid <= '0;
        end else if (w_wr_ok) begin
            r_valid[wr_addr] <= 1'b1;
        end
    end

    // Valid tag and address travel alongside the RAM read latency
    always_ff @(posedge CLK_50 or posedge SW) begin
        if (SW) begin
            r_rd_valid <= 1'b0;
            r_rd_addr  <= 8'd0;
        end else begin
            r_rd_valid <= r_valid[r_addr];
            r_rd_addr  <= r_addr;
        end
    end

    // Sticky flag for writes dropped because a scan was running
    always_ff @(posedge CLK_50 or posedge SW) begin
        if (SW) begin
            wr_collision <= 1'b0;
        end else if (clear || w_start_ok) begin
            wr_collision <= 1'b0;
        end else if (wr_en && w_busy) begin
            wr_collision <= 1'b1;
        end
    end

    // Scan sequencer with accumulators and registered result outputs
    always_ff @(posedge CLK_50 or posedge SW) begin
        if (SW) begin
            r_state      <= ST_IDLE;
            r_addr       <= 8'd0;
            r_best       <= '0;
            r_runner     <= '0;
            r_idx        <= 8'd0;
            done         <= 1'b0;
            max_byte     <= 8'd0;
            max_delay    <= '0;
            runner_delay <= '0;
            margin       <= '0;
            found        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                r_state      <= ST_IDLE;
                max_byte     <= 8'd0;
                max_delay    <= '0;
                runner_delay <= '0;
                margin       <= '0;
                found        <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_best   <= '0;
                            r_runner <= '0;
                            r_idx    <= 8'd0;
                            r_addr   <= SCAN_FIRST;
                            r_state  <= ST_PRIME;
                        end
                    end
                    ST_PRIME: begin
                        if (c_SINGLE) begin
                            r_state <= ST_LAST;
                        end else begin
                            r_addr  <= r_addr + 8'd1;
                            r_state <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        r_best   <= w_best_n;
                        r_runner <= w_runner_n;
                        r_idx    <= w_idx_n;
                        // Holding the address at SCAN_LAST avoids wrapping past 8'hFF
                        if (r_addr == SCAN_LAST) begin
                            r_state <= ST_LAST;
                        end else begin
                            r_addr <= r_addr + 8'd1;
                        end
                    end
                    ST_LAST: begin
                        r_best   <= w_best_n;
                        r_runner <= w_runner_n;
                        r_idx    <= w_idx_n;
                        r_state  <= ST_REPORT;
                    end
                    ST_REPORT: begin
                        max_byte     <= (|r_best) ? r_idx : 8'd0;
                        max_delay    <= r_best;
                        runner_delay <= r_runner;
                        margin       <= r_best - r_runner;
                        found        <= |r_best;
                        done         <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_delay_peak_finder.sv
//------------------------------------------------------------------------------
// Module   : tb_delay_peak_finder
// Brief    : Scoreboard bench for delay_peak_finder. Stimulus pushes the
//            expected scan result when it issues start; a monitor pops and
//            compares whenever done pulses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_delay_peak_finder;

    localparam int LAT = 252;

    logic        CLK_50;
    logic        SW;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clear;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  max_byte;
    logic [31:0] max_delay;
    logic [31:0] runner_delay;
    logic [31:0] margin;
    logic        found;
    logic        wr_collision;

    typedef struct {
        logic [7:0]  mb;
        logic [31:0] md;
        logic [31:0] rd;
        logic [31:0] mg;
        logic        fnd;
        logic        coll;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    delay_peak_finder dut (
        .CLK_50       (CLK_50),
        .SW           (SW),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .clear        (clear),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .max_byte     (max_byte),
        .max_delay    (max_delay),
        .runner_delay (runner_delay),
        .margin       (margin),
        .found        (found),
        .wr_collision (wr_collision)
    );

    initial CLK_50 = 1'b0;
    always #5 CLK_50 = ~CLK_50;

    always @(posedge CLK_50) cycle <= cycle + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic [7:0] mb, input logic [31:0] md, input logic [31:0] rd,
                                input logic fnd, input logic coll);
        exp_t e;
        e.mb = mb; e.md = md; e.rd = rd; e.mg = md - rd; e.fnd = fnd; e.coll = coll; e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge CLK_50) begin
        if (!SW && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending scan", cycle);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cycle, e.cyc);
                chk("max_byte", 32'(max_byte), 32'(e.mb));
                chk("max_delay", max_delay, e.md);
                chk("runner_delay", runner_delay, e.rd);
                chk("margin", margin, e.mg);
                chk("found", 32'(found), 32'(e.fnd));
                chk("wr_collision", 32'(wr_collision), 32'(e.coll));
                chk("busy_with_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic write(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_start(input bit expect_done, input exp_t e);
        exp_t x;
        x = e;
        if (expect_done) begin
            x.cyc = cycle + 1 + LAT;
            sb.push_back(x);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        chk("scan_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_max_byte"}, 32'(max_byte), 32'd0);
        chk({tag, "_max_delay"}, max_delay, 32'd0);
        chk({tag, "_runner"}, runner_delay, 32'd0);
        chk({tag, "_margin"}, margin, 32'd0);
        chk({tag, "_found"}, 32'(found), 32'd0);
        chk({tag, "_coll"}, 32'(wr_collision), 32'd0);
    endtask

    initial begin
        SW = 1'b1; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 32'd0; clear = 1'b0; start = 1'b0;
        repeat (3) tick();
        SW = 1'b0;
        tick();
        chk_outputs_zero("reset");

        // Start with nothing written: empty result after 252 cycles
        do_start(1'b1, mk(8'h00, 32'd0, 32'd0, 1'b0, 1'b0));
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_idle();

        // Flat 100 with one peak of 2000 at 0x41
        do_clear();
        for (int a = 6; a < 256; a++) begin
            write(8'(a), (a == 8'h41) ? 32'd2000 : 32'd100);
        end
        do_start(1'b1, mk(8'h41, 32'd2000, 32'd100, 1'b1, 1'b0));
        wait_idle();

        // Tie at 500: lowest index wins, zero margin
        do_clear();
        write(8'h20, 32'd500);
        write(8'h90, 32'd500);
        do_start(1'b1, mk(8'h20, 32'd500, 32'd500, 1'b1, 1'b0));
        wait_idle();

        // Extremes at both ends of the range, no wrap past 0xFF
        do_clear();
        write(8'hFF, 32'hFFFF_FFFF);
        write(8'h06, 32'hFFFF_FFFE);
        do_start(1'b1, mk(8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0));
        wait_idle();

        // Write arriving mid-scan is dropped and flagged
        do_clear();
        write(8'h30, 32'd100);
        do_start(1'b1, mk(8'h30, 32'd100, 32'd0, 1'b1, 1'b1));
        repeat (9) tick();
        write(8'h50, 32'd5000);
        wait_idle();
        chk("collision_sticky", 32'(wr_collision), 32'd1);

        // Second scan aborted by clear at cycle 50
        do_start(1'b0, mk(8'h00, 32'd0, 32'd0, 1'b0, 1'b0));
        chk("collision_cleared_by_start", 32'(wr_collision), 32'd0);
        repeat (3) tick();
        write(8'h50, 32'd5000);
        repeat (45) tick();
        do_clear();
        chk_outputs_zero("clear_abort");
        repeat (260) tick();

        // Async reset mid-scan, then verify the bitmap was wiped
        write(8'h10, 32'd777);
        do_start(1'b1, mk(8'h10, 32'd777, 32'd0, 1'b1, 1'b0));
        wait_idle();
        do_start(1'b0, mk(8'h00, 32'd0, 32'd0, 1'b0, 1'b0));
        repeat (4) tick();
        write(8'h60, 32'd9);
        repeat (25) tick();
        #2 SW = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        tick();
        SW = 1'b0;
        tick();
        do_start(1'b1, mk(8'h00, 32'd0, 32'd0, 1'b0, 1'b0));
        wait_idle();

        repeat (5) tick();
        chk("pending_scans", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
